ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the program/data RAM wrapper's single issue slot between the instruction-fetch (IF) and data-memory (DM)
//  requesters; at most one access is issued to the RAM per cycle. Returns synchronous read data to the owner one
//  cycle after its grant. Blocks all grants while the UART programmer owns the RAM (prog_mode_i).
//  Sits between core fetch/LSU and the RAM wrapper.
// PARAMETERS
//  NB_COL     4       byte columns per word; DW = NB_COL*COL_WIDTH
//  COL_WIDTH  8       bits per column
//  RAM_DEPTH  131072  words; AW = $clog2(RAM_DEPTH)
//  MAX_STALL  4       consecutive IF denials before IF takes priority (>=1)
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        asynchronous active-low reset
//  if_req_i       in   1        IF read request (held until gnt)
//  if_addr_i      in   AW       IF word address
//  if_gnt_o       out  1        IF request accepted this cycle
//  if_rvalid_o    out  1        IF read data valid
//  if_rdata_o     out  DW       IF read data
//  dm_req_i       in   1        DM request (held until gnt)
//  dm_we_i        in   NB_COL   byte write enables; 0 = read
//  dm_addr_i      in   AW       DM word address
//  dm_wdata_i     in   DW       DM write data
//  dm_gnt_o       out  1        DM request accepted this cycle
//  dm_rvalid_o    out  1        DM read data valid / write ack
//  dm_rdata_o     out  DW       DM read data
//  ram_rd_en_o    out  1        to wrapper rd_en
//  ram_rd_addr_o  out  AW       to wrapper rd_addr
//  ram_wr_en_o    out  NB_COL   to wrapper wr_en
//  ram_wr_addr_o  out  AW       to wrapper wr_addr
//  ram_wr_data_o  out  DW       to wrapper wr_data
//  ram_rd_data_i  in   DW       from wrapper rd_data (1-cycle latency)
//  prog_mode_i    in   1        programmer active; lock RAM
//  busy_o         out  1        response outstanding or locked
// BEHAVIOUR
//  Reset: all *_gnt_o, *_rvalid_o, ram_rd_en_o, ram_wr_en_o = 0; state = DM_PRIO; stall_cnt = 0; owner tag = NONE.
//  Grants combinational from req/state; at most one of if_gnt_o/dm_gnt_o per cycle; no grant while prog_mode_i=1.
//  FSM: DM_PRIO - DM wins ties; IF_PRIO - IF wins ties; LOCKED - no grants.
//   any -> LOCKED when prog_mode_i=1; LOCKED -> DM_PRIO when prog_mode_i=0 (stall_cnt cleared).
//   DM_PRIO -> IF_PRIO when stall_cnt reaches MAX_STALL; IF_PRIO -> DM_PRIO on IF grant.
//  stall_cnt (width $clog2(MAX_STALL+1)): +1 each cycle if_req_i=1 and not granted, saturating at MAX_STALL;
//   cleared on IF grant or if_req_i=0.
//  Issue: granted read -> ram_rd_en_o=1, ram_rd_addr_o=addr; granted DM write -> ram_wr_en_o=dm_we_i,
//   ram_wr_addr_o/ram_wr_data_o=DM fields. ram_wr_en_o=0 when no DM write is granted.
//  Response: registered owner tag; exactly 1 cycle after grant the owner's rvalid pulses for one cycle.
//   *_rdata_o = ram_rd_data_i. DM write also returns rvalid (ack) 1 cycle later; rdata don't-care.
//  Throughput: back-to-back grants allowed (1 access/cycle). A DM write followed next cycle by any read of the
//   same address returns new data.
//  Lock entry mid-transfer: an access granted the cycle before prog_mode_i rises still gets its rvalid.
//   No grant is issued in the cycle prog_mode_i=1.
//  busy_o = (owner tag != NONE) | (state == LOCKED).
//  Async reset mid-response drops the pending rvalid (no late pulse after reset release).
// STRUCTURE
//  ram_arb_pkg: typedef enum {ARB_DM_PRIO, ARB_IF_PRIO, ARB_LOCKED} arb_state_t;
//   typedef enum {OWN_NONE, OWN_IF, OWN_DM} arb_owner_t.
//  Sub-module ram_arb_stall_ctr (saturating starvation counter + priority-flip flag).
//   Everything else is flat in ram_port_arbiter.
// TESTING
//  1 IF only, addr 0x10,0x11,0x12 on consecutive cycles -> 3 grants back-to-back; if_rvalid_o cycles 1..3
//    with preloaded words.
//  2 DM write we=4'b0011 data 0xAABBCCDD addr 0x20 (old 0x11223344), then DM read 0x20
//    -> rdata 0x1122CCDD; ack rvalid after the write.
//  3 IF and DM requesting continuously, MAX_STALL=4 -> DM granted 4 cycles, IF 5th, pattern repeats;
//    IF never waits >4 cycles.
//  4 prog_mode_i rises the cycle after a DM read grant -> dm_rvalid_o=1 next cycle, no grants while high;
//    DM_PRIO after it falls.
//  5 rst_ni pulsed low for 1 cycle with an IF read outstanding -> if_rvalid_o=0 immediately and after release;
//    stall_cnt=0.
//  6 Simultaneous IF read and DM write, same addr 0x30 in DM_PRIO -> DM write first; IF read next cycle
//    returns written data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Purpose: shared types for the RAM port arbiter (FSM states, response owner tag).
// Latency: n/a (types only).
// Backpressure: n/a.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_DM_PRIO,
      ARB_IF_PRIO,
      ARB_LOCKED
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } arb_owner_t;

endpackage

// File: rtl/ram_arb_stall_ctr.sv
// Purpose: counts consecutive cycles the IF requester is denied and raises a priority-flip flag.
// Latency: flip_o is combinational from this cycle's request/grant (it reflects the next count).
// Backpressure: none; a pure observer of the IF handshake.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   if_req_i       IF request pending this cycle
//   if_gnt_i       IF granted this cycle
//   clr_i          force the count to zero (RAM locked by the programmer)
//   flip_o         next count has reached MAX_STALL: IF must take priority next cycle
module ram_arb_stall_ctr #(
   parameter int unsigned MAX_STALL = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic if_req_i,
   input  logic if_gnt_i,
   input  logic clr_i,
   output logic flip_o
);

   localparam int unsigned SW = $clog2(MAX_STALL + 1);
   localparam logic [SW-1:0] MAX_CNT = SW'(MAX_STALL);

   logic [SW-1:0] stall_d;
   logic [SW-1:0] stall_q;

   always_comb begin
      stall_d = stall_q;
      if (clr_i || !if_req_i || if_gnt_i) begin
         stall_d = '0;
      end else if (stall_q != MAX_CNT) begin
         stall_d = stall_q + 1'b1;
      end
   end

   // Flag on the next value so the flip lands right after the MAX_STALL-th denial,
   // giving IF the grant on its (MAX_STALL+1)-th waiting cycle.
   assign flip_o = (stall_d == MAX_CNT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose: shares the single RAM issue slot between instruction fetch (IF) and data memory (DM).
// Latency: grant combinational; rvalid/rdata to the owner exactly one cycle after its grant.
// Backpressure: requests are held until granted; no grants while prog_mode_i is high.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   if_req/addr, if_gnt/rvalid/rdata    instruction fetch read port
//   dm_req/we/addr/wdata, dm_gnt/rvalid/rdata  data port (we=0 read, else byte-write with ack)
//   ram_rd_*, ram_wr_*, ram_rd_data_i   RAM wrapper interface (1-cycle read latency)
//   prog_mode_i                         programmer owns the RAM
//   busy_o                              response outstanding or locked
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned NB_COL    = 4,
   parameter int unsigned COL_WIDTH = 8,
   parameter int unsigned RAM_DEPTH = 131072,
   parameter int unsigned MAX_STALL = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 if_req_i,
   input  logic [$clog2(RAM_DEPTH)-1:0]         if_addr_i,
   output logic                                 if_gnt_o,
   output logic                                 if_rvalid_o,
   output logic [NB_COL*COL_WIDTH-1:0]          if_rdata_o,
   input  logic                                 dm_req_i,
   input  logic [NB_COL-1:0]                    dm_we_i,
   input  logic [$clog2(RAM_DEPTH)-1:0]         dm_addr_i,
   input  logic [NB_COL*COL_WIDTH-1:0]          dm_wdata_i,
   output logic                                 dm_gnt_o,
   output logic                                 dm_rvalid_o,
   output logic [NB_COL*COL_WIDTH-1:0]          dm_rdata_o,
   output logic                                 ram_rd_en_o,
   output logic [$clog2(RAM_DEPTH)-1:0]         ram_rd_addr_o,
   output logic [NB_COL-1:0]                    ram_wr_en_o,
   output logic [$clog2(RAM_DEPTH)-1:0]         ram_wr_addr_o,
   output logic [NB_COL*COL_WIDTH-1:0]          ram_wr_data_o,
   input  logic [NB_COL*COL_WIDTH-1:0]          ram_rd_data_i,
   input  logic                                 prog_mode_i,
   output logic                                 busy_o
);

   arb_state_t state_d, state_q;
   arb_owner_t owner_d, owner_q;
   logic       if_gnt;
   logic       dm_gnt;
   logic       flip;
   logic       stall_clr;

   // Grant selection: the state only decides who wins a tie.
   always_comb begin
      if_gnt = 1'b0;
      dm_gnt = 1'b0;
      if (!prog_mode_i) begin
         unique case (state_q)
            ARB_DM_PRIO: begin
               dm_gnt = dm_req_i;
               if_gnt = if_req_i & ~dm_req_i;
            end
            ARB_IF_PRIO: begin
               if_gnt = if_req_i;
               dm_gnt = dm_req_i & ~if_req_i;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      if (prog_mode_i) begin
         state_d = ARB_LOCKED;
      end else begin
         unique case (state_q)
            ARB_LOCKED:  state_d = ARB_DM_PRIO;
            ARB_DM_PRIO: if (flip)   state_d = ARB_IF_PRIO;
            ARB_IF_PRIO: if (if_gnt) state_d = ARB_DM_PRIO;
            default:     state_d = ARB_DM_PRIO;
         endcase
      end
   end

   always_comb begin
      owner_d = OWN_NONE;
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (dm_gnt) begin
         owner_d = OWN_DM;
      end
   end

   assign stall_clr = prog_mode_i | (state_q == ARB_LOCKED);

   ram_arb_stall_ctr #(
      .MAX_STALL (MAX_STALL)
   ) u_stall (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .if_req_i (if_req_i),
      .if_gnt_i (if_gnt),
      .clr_i    (stall_clr),
      .flip_o   (flip)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ARB_DM_PRIO;
         owner_q <= OWN_NONE;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // RAM issue: DM with all byte enables low is a read.
   assign ram_rd_en_o   = if_gnt | (dm_gnt & (dm_we_i == '0));
   assign ram_rd_addr_o = if_gnt ? if_addr_i : dm_addr_i;
   assign ram_wr_en_o   = dm_gnt ? dm_we_i : '0;
   assign ram_wr_addr_o = dm_addr_i;
   assign ram_wr_data_o = dm_wdata_i;

   assign if_gnt_o    = if_gnt;
   assign dm_gnt_o    = dm_gnt;
   assign if_rvalid_o = (owner_q == OWN_IF);
   assign dm_rvalid_o = (owner_q == OWN_DM);
   assign if_rdata_o  = ram_rd_data_i;
   assign dm_rdata_o  = ram_rd_data_i;
   assign busy_o      = (owner_q != OWN_NONE) | (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: directed self-checking bench for ram_port_arbiter with a behavioural 1-cycle RAM.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: requests held by the bench until granted.
module tb_ram_port_arbiter;

   logic        clk_i;
   logic        rst_ni;
   logic        if_req_i;
   logic [16:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        dm_req_i;
   logic [3:0]  dm_we_i;
   logic [16:0] dm_addr_i;
   logic [31:0] dm_wdata_i;
   logic        dm_gnt_o;
   logic        dm_rvalid_o;
   logic [31:0] dm_rdata_o;
   logic        ram_rd_en_o;
   logic [16:0] ram_rd_addr_o;
   logic [3:0]  ram_wr_en_o;
   logic [16:0] ram_wr_addr_o;
   logic [31:0] ram_wr_data_o;
   logic [31:0] ram_rd_data_i;
   logic        prog_mode_i;
   logic        busy_o;

   logic        tb_load;
   logic [31:0] mem [0:255];
   int          checks;
   int          failures;

   ram_port_arbiter #(
      .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(131072), .MAX_STALL(4)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
      .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
      .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o),
      .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
      .ram_rd_data_i(ram_rd_data_i), .prog_mode_i(prog_mode_i), .busy_o(busy_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural RAM wrapper: byte-enabled write, synchronous read with 1-cycle latency.
   always @(posedge clk_i) begin
      if (tb_load) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 32'hA0A0_0000 | 32'(i);
         end
         mem[8'h20] <= 32'h1122_3344;
         mem[8'h30] <= 32'h5566_7788;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (ram_wr_en_o[b]) mem[ram_wr_addr_o[7:0]][b*8 +: 8] <= ram_wr_data_o[b*8 +: 8];
         end
         if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o[7:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      int wait_cnt;
      int max_wait;
      checks   = 0;
      failures = 0;
      tb_load  = 1'b1;
      rst_ni   = 1'b0;
      if_req_i = 1'b0; if_addr_i = '0;
      dm_req_i = 1'b0; dm_we_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
      prog_mode_i = 1'b0;

      // Reset state
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
      chk("rst_dm_rvalid", 32'(dm_rvalid_o), 32'd0);
      chk("rst_wr_en", 32'(ram_wr_en_o), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_stall", 32'(dut.u_stall.stall_q), 32'd0);
      tb_load = 1'b0;
      rst_ni  = 1'b1;

      // 1: IF back-to-back reads 0x10..0x12
      next_cycle(); if_req_i = 1'b1; if_addr_i = 17'h10;
      @(negedge clk_i);
      chk("t1_gnt0", 32'(if_gnt_o), 32'd1);
      chk("t1_rd_en0", 32'(ram_rd_en_o), 32'd1);
      chk("t1_rd_addr0", 32'(ram_rd_addr_o), 32'h10);
      chk("t1_dm_gnt0", 32'(dm_gnt_o), 32'd0);
      next_cycle(); if_addr_i = 17'h11;
      @(negedge clk_i);
      chk("t1_gnt1", 32'(if_gnt_o), 32'd1);
      chk("t1_rv1", 32'(if_rvalid_o), 32'd1);
      chk("t1_rdata1", if_rdata_o, 32'hA0A0_0010);
      next_cycle(); if_addr_i = 17'h12;
      @(negedge clk_i);
      chk("t1_gnt2", 32'(if_gnt_o), 32'd1);
      chk("t1_rdata2", if_rdata_o, 32'hA0A0_0011);
      next_cycle(); if_req_i = 1'b0;
      @(negedge clk_i);
      chk("t1_rv3", 32'(if_rvalid_o), 32'd1);
      chk("t1_rdata3", if_rdata_o, 32'hA0A0_0012);
      chk("t1_gnt_idle", 32'(if_gnt_o), 32'd0);
      next_cycle();
      @(negedge clk_i);
      chk("t1_rv_end", 32'(if_rvalid_o), 32'd0);

      // 2: partial DM write then read-back
      next_cycle(); dm_req_i = 1'b1; dm_we_i = 4'b0011; dm_addr_i = 17'h20; dm_wdata_i = 32'hAABB_CCDD;
      @(negedge clk_i);
      chk("t2_wgnt", 32'(dm_gnt_o), 32'd1);
      chk("t2_wr_en", 32'(ram_wr_en_o), 32'h3);
      chk("t2_wr_addr", 32'(ram_wr_addr_o), 32'h20);
      chk("t2_wr_rd_en", 32'(ram_rd_en_o), 32'd0);
      next_cycle(); dm_we_i = 4'b0000;
      @(negedge clk_i);
      chk("t2_rgnt", 32'(dm_gnt_o), 32'd1);
      chk("t2_ack", 32'(dm_rvalid_o), 32'd1);
      chk("t2_rd_en", 32'(ram_rd_en_o), 32'd1);
      chk("t2_rd_wr_en", 32'(ram_wr_en_o), 32'd0);
      next_cycle(); dm_req_i = 1'b0;
      @(negedge clk_i);
      chk("t2_rv", 32'(dm_rvalid_o), 32'd1);
      chk("t2_rdata", dm_rdata_o, 32'h1122_CCDD);
      chk("t2_busy", 32'(busy_o), 32'd1);
      next_cycle();
      @(negedge clk_i);
      chk("t2_idle_rv", 32'(dm_rvalid_o), 32'd0);
      chk("t2_idle_busy", 32'(busy_o), 32'd0);

      // 3: continuous contention; DM x4 then IF, repeating
      wait_cnt = 0;
      max_wait = 0;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         if_req_i = 1'b1; if_addr_i = 17'h10;
         dm_req_i = 1'b1; dm_we_i = 4'b0000; dm_addr_i = 17'h11;
         @(negedge clk_i);
         chk($sformatf("t3_if_gnt%0d", i), 32'(if_gnt_o), (i % 5 == 4) ? 32'd1 : 32'd0);
         chk($sformatf("t3_dm_gnt%0d", i), 32'(dm_gnt_o), (i % 5 == 4) ? 32'd0 : 32'd1);
         if (if_gnt_o) wait_cnt = 0;
         else wait_cnt++;
         if (wait_cnt > max_wait) max_wait = wait_cnt;
      end
      chk("t3_max_wait", 32'(max_wait), 32'd4);
      next_cycle(); if_req_i = 1'b0; dm_req_i = 1'b0;
      next_cycle();

      // 4: programmer lock right after a DM read grant
      next_cycle(); dm_req_i = 1'b1; dm_addr_i = 17'h12;
      @(negedge clk_i);
      chk("t4_gnt", 32'(dm_gnt_o), 32'd1);
      next_cycle(); prog_mode_i = 1'b1; if_req_i = 1'b1; if_addr_i = 17'h13;
      @(negedge clk_i);
      chk("t4_rv", 32'(dm_rvalid_o), 32'd1);
      chk("t4_rdata", dm_rdata_o, 32'hA0A0_0012);
      chk("t4_no_dm_gnt", 32'(dm_gnt_o), 32'd0);
      chk("t4_no_if_gnt", 32'(if_gnt_o), 32'd0);
      chk("t4_no_rd_en", 32'(ram_rd_en_o), 32'd0);
      next_cycle();
      @(negedge clk_i);
      chk("t4_lock_rv", 32'(dm_rvalid_o), 32'd0);
      chk("t4_lock_gnt", 32'({if_gnt_o, dm_gnt_o}), 32'd0);
      chk("t4_lock_busy", 32'(busy_o), 32'd1);
      next_cycle(); prog_mode_i = 1'b0;
      @(negedge clk_i);
      chk("t4_exit_gnt", 32'({if_gnt_o, dm_gnt_o}), 32'd0);
      chk("t4_exit_busy", 32'(busy_o), 32'd1);
      next_cycle();
      @(negedge clk_i);
      chk("t4_dmprio_dm", 32'(dm_gnt_o), 32'd1);
      chk("t4_dmprio_if", 32'(if_gnt_o), 32'd0);
      next_cycle(); if_req_i = 1'b0; dm_req_i = 1'b0;
      next_cycle();

      // 5: async reset pulse with an IF read outstanding
      next_cycle(); if_req_i = 1'b1; if_addr_i = 17'h11;
      @(negedge clk_i);
      chk("t5_gnt", 32'(if_gnt_o), 32'd1);
      next_cycle();
      chk("t5_rv_pre", 32'(if_rvalid_o), 32'd1);
      rst_ni = 1'b0; if_req_i = 1'b0;
      #1;
      chk("t5_rv_in_rst", 32'(if_rvalid_o), 32'd0);
      chk("t5_busy_in_rst", 32'(busy_o), 32'd0);
      next_cycle(); rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t5_rv_after", 32'(if_rvalid_o), 32'd0);
      chk("t5_stall", 32'(dut.u_stall.stall_q), 32'd0);
      next_cycle();
      @(negedge clk_i);
      chk("t5_rv_late", 32'(if_rvalid_o), 32'd0);

      // 6: IF read and DM write collide on 0x30 in DM_PRIO
      next_cycle();
      if_req_i = 1'b1; if_addr_i = 17'h30;
      dm_req_i = 1'b1; dm_we_i = 4'b1111; dm_addr_i = 17'h30; dm_wdata_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      chk("t6_dm_gnt", 32'(dm_gnt_o), 32'd1);
      chk("t6_if_wait", 32'(if_gnt_o), 32'd0);
      chk("t6_wr_en", 32'(ram_wr_en_o), 32'hF);
      next_cycle(); dm_req_i = 1'b0; dm_we_i = 4'b0000;
      @(negedge clk_i);
      chk("t6_if_gnt", 32'(if_gnt_o), 32'd1);
      chk("t6_ack", 32'(dm_rvalid_o), 32'd1);
      chk("t6_rd_addr", 32'(ram_rd_addr_o), 32'h30);
      next_cycle(); if_req_i = 1'b0;
      @(negedge clk_i);
      chk("t6_rv", 32'(if_rvalid_o), 32'd1);
      chk("t6_rdata", if_rdata_o, 32'hDEAD_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
